// File: rtl/delaychain_tester_if.sv
// rtl/delaychain_tester_if.sv - chain-side signals between the tester and the delay chain under test
interface delaychain_tester_if;
    logic chain_din;
    logic chain_test;
    logic chain_dout;

    modport master (
        output chain_din,
        output chain_test,
        input  chain_dout
    );

    modport slave (
        input  chain_din,
        input  chain_test,
        output chain_dout
    );
endinterface

// File: rtl/delaychain_tester.sv
// rtl/delaychain_tester.sv - pattern generator and response checker wrapped around one delay chain
module delaychain_tester #(
    parameter int N_CYCLES = 256,
    parameter int LAT      = 2,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  test_sel,
    delaychain_tester_if.master   chain,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [15:0]           first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]      N_END    = 16'(N_CYCLES);
    localparam logic [15:0]      LAST_IDX = 16'(N_CYCLES - 1);
    localparam logic [15:0]      NO_ERR   = 16'hFFFF;
    localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};
    localparam logic [7:0]       SEED     = 8'h01;

    function automatic logic pat_bit(input logic [1:0] m, input logic i0, input logic [7:0] l);
        case (m)
            2'b00:   return 1'b0;
            2'b01:   return i0;
            2'b10:   return l[7];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    state_t           state_q;
    logic [1:0]       mode_q;
    logic [15:0]      idx_q;
    logic [7:0]       lfsr_q;
    logic             din_q;
    logic             test_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [15:0]      first_q;

    // Expected-value pipeline: stage 0 is loaded alongside chain_din, stage LAT is compared.
    logic [LAT:0]     pv_q;
    logic [LAT:0]     pb_q;
    logic [15:0]      pi_q [0:LAT];

    logic             start_bit;
    logic             run_bit;
    logic             cmp_valid;
    logic             mismatch;
    logic             last_cmp;
    logic [CNT_W-1:0] err_d;
    logic [15:0]      first_d;

    always_comb begin
        start_bit = pat_bit(mode, 1'b0, SEED);
        run_bit   = pat_bit(mode_q, idx_q[0], lfsr_q);
        cmp_valid = pv_q[LAT] && (state_q == S_RUN || state_q == S_DRAIN);
        mismatch  = cmp_valid && (pb_q[LAT] != chain.chain_dout);
        last_cmp  = pv_q[LAT] && (pi_q[LAT] == LAST_IDX);
        err_d     = err_q;
        first_d   = first_q;
        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + CNT_W'(1);
            end
            if (first_q == NO_ERR) begin
                first_d = pi_q[LAT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            idx_q   <= '0;
            lfsr_q  <= '0;
            din_q   <= 1'b0;
            test_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= NO_ERR;
            pv_q    <= '0;
            pb_q    <= '0;
            for (int j = 0; j <= LAT; j++) begin
                pi_q[j] <= '0;
            end
        end else begin
            for (int j = LAT; j >= 1; j--) begin
                pv_q[j] <= pv_q[j-1];
                pb_q[j] <= pb_q[j-1];
                pi_q[j] <= pi_q[j-1];
            end
            pv_q[0] <= 1'b0;
            pb_q[0] <= 1'b0;
            pi_q[0] <= '0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        mode_q  <= mode;
                        test_q  <= test_sel;
                        idx_q   <= 16'd1;
                        lfsr_q  <= lfsr_step(SEED);
                        din_q   <= start_bit;
                        pv_q[0] <= 1'b1;
                        pb_q[0] <= start_bit;
                        pi_q[0] <= '0;
                        err_q   <= '0;
                        first_q <= NO_ERR;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end

                S_RUN: begin
                    err_q   <= err_d;
                    first_q <= first_d;
                    if (idx_q == N_END) begin
                        state_q <= S_DRAIN;
                        din_q   <= 1'b0;
                    end else begin
                        din_q   <= run_bit;
                        pv_q[0] <= 1'b1;
                        pb_q[0] <= run_bit;
                        pi_q[0] <= idx_q;
                        idx_q   <= idx_q + 16'd1;
                        lfsr_q  <= lfsr_step(lfsr_q);
                    end
                end

                S_DRAIN: begin
                    err_q   <= err_d;
                    first_q <= first_d;
                    if (last_cmp) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chain.chain_din  = din_q;
    assign chain.chain_test = test_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_err_idx    = first_q;

endmodule

// File: tb/tb_delaychain_tester.sv
// tb/tb_delaychain_tester.sv - randomized directed bench for delaychain_tester with a behavioural chain and result model
module tb_delaychain_tester;

    localparam int N     = 256;
    localparam int LAT   = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       mode;
    logic             test_sel;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [15:0]      first_err_idx;

    delaychain_tester_if chain_if ();

    delaychain_tester #(.N_CYCLES(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .test_sel      (test_sel),
        .chain         (chain_if),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal two-flop chain with optional stuck-at-0 output and per-bit flips on the sampled input.
    int   tcyc = 0;
    int   kbase = 0;
    logic inj = 1'b0;
    int   fault = 0;
    logic flip_mem [N];
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    always @(posedge clk) begin
        tcyc <= tcyc + 1;
        s1   <= chain_if.chain_din ^ (inj && (tcyc - kbase) >= 0 && (tcyc - kbase) < N
                                      && flip_mem[(tcyc - kbase) % N]);
        s2   <= s1;
    end
    assign chain_if.chain_dout = (fault == 1) ? 1'b0 : s2;

    int n_cmp = 0;
    int n_bad = 0;
    logic pat [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_din"},   32'(chain_if.chain_din),  32'd0);
        chk({tag, "_test"},  32'(chain_if.chain_test), 32'd0);
        chk({tag, "_busy"},  32'(busy),                32'd0);
        chk({tag, "_done"},  32'(done),                32'd0);
        chk({tag, "_pass"},  32'(pass),                32'd0);
        chk({tag, "_err"},   32'(err_count),           32'd0);
        chk({tag, "_first"}, 32'(first_err_idx),       32'hFFFF);
    endtask

    // Pattern straight from the mode rules: constant, index parity, or Fibonacci LFSR seeded 0x01.
    task automatic build_pattern(input logic [1:0] m);
        logic [7:0] l;
        logic       fb;
        l = 8'h01;
        for (int i = 0; i < N; i++) begin
            case (m)
                2'b00: pat[i] = 1'b0;
                2'b01: pat[i] = (i % 2 == 1);
                2'b10: pat[i] = l[7];
                default: pat[i] = 1'b1;
            endcase
            fb = l[7] ^ l[5] ^ l[4] ^ l[3];
            l  = {l[6:0], fb};
        end
    endtask

    task automatic do_run(input string tag, input logic [1:0] m, input logic ts, input int flt,
                          input int flip_rate, input int mid_start, input int abort_at);
        int exp_cnt;
        int exp_first;
        int din_bad;
        int test_bad;
        int ctl_bad;
        logic obs_bit;
        logic exp_din;
        bit aborted;
        exp_cnt = 0; exp_first = 32'hFFFF; din_bad = 0; test_bad = 0; ctl_bad = 0; aborted = 0;
        build_pattern(m);
        for (int i = 0; i < N; i++) begin
            flip_mem[i] = (flip_rate > 0) && ($urandom_range(flip_rate - 1) == 0);
            obs_bit = (flt == 1) ? 1'b0 : (pat[i] ^ flip_mem[i]);
            if (obs_bit != pat[i]) begin
                exp_cnt++;
                if (exp_first == 32'hFFFF) exp_first = i;
            end
        end
        fault = flt;

        @(negedge clk);
        mode = m; test_sel = ts; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; kbase = tcyc; inj = 1'b1;
        for (int j = 0; j <= N + LAT; j++) begin
            exp_din = (j < N) ? pat[j] : 1'b0;
            if (chain_if.chain_din !== exp_din) din_bad++;
            if (chain_if.chain_test !== ts) test_bad++;
            if (busy !== (j < N + LAT)) ctl_bad++;
            if (done !== (j == N + LAT)) ctl_bad++;
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_values({tag, "_abort"});
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            start = (j == mid_start);
            mode = 2'($urandom);
            test_sel = 1'($urandom);
            if (j < N + LAT) @(negedge clk);
        end
        start = 1'b0;
        inj = 1'b0;
        chk({tag, "_din_seq"},  32'(din_bad),  32'd0);
        chk({tag, "_test_hold"}, 32'(test_bad), 32'd0);
        chk({tag, "_busy_done_timing"}, 32'(ctl_bad), 32'd0);
        if (!aborted) begin
            chk({tag, "_err"},   32'(err_count),     32'((exp_cnt > 255) ? 255 : exp_cnt));
            chk({tag, "_first"}, 32'(first_err_idx), 32'(exp_first));
            chk({tag, "_pass"},  32'(pass),          32'(exp_cnt == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; test_sel = 1'b0;
        for (int i = 0; i < N; i++) flip_mem[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_run("ideal_toggle",   2'b01, 1'b0, 0, 0, -1, -1);
        do_run("stuck_toggle",   2'b01, 1'b0, 1, 0, -1, -1);
        do_run("stuck_allone",   2'b11, 1'b1, 1, 0, -1, -1);
        do_run("lfsr_test1",     2'b10, 1'b1, 0, 0, -1, -1);
        do_run("mid_start",      2'b10, 1'b0, 0, 0, N / 2, -1);
        do_run("abort",          2'b01, 1'b1, 0, 0, -1, 100);
        check_reset_values("post_abort");
        do_run("after_abort",    2'b11, 1'b0, 0, 0, -1, -1);
        do_run("b2b_ideal",      2'b00, 1'b1, 0, 0, -1, -1);
        for (int r = 0; r < 4; r++) begin
            do_run($sformatf("rand%0d", r), 2'($urandom), 1'($urandom), 0, 8 + 8 * r, -1, -1);
        end
        do_run("rand_dense",     2'b10, 1'b0, 0, 2, -1, -1);
        do_run("final_ideal",    2'b01, 1'b0, 0, 0, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
